// File: rtl/load_store_unit.sv
// Memory-access stage between execute and writeback: steers store byte lanes, extends loads,
// reports the in-flight store size for hazard checks and abandons accesses the bus never finishes.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [1:0]  ex_op,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_wr,
    output logic [1:0]  st_cntr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0] CAUSE_WIDTH      = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'b11;
    localparam logic [8:0] TIMEOUT_W        = 9'(TIMEOUT);

    typedef struct packed {
        logic        is_load;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
        logic [4:0]  rd;
        logic        reg_wr;
        logic [7:0]  cnt;
        logic [1:0]  st_cntr;
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_be;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        fault;
        logic [1:0]  fault_cause;
    } regs_t;

    state_t state_q, state_d;
    regs_t  regs_q, regs_d;

    logic        is_load_in, is_store_in, width_ok, misaligned, timed_out;
    logic [1:0]  size_in;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, shifted, load_val;
    logic [8:0]  cnt_inc;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            regs_q  <= '0;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
        end
    end

    // Decode of the instruction presented by execute.
    always_comb begin
        is_load_in  = (ex_op == 2'b01);
        is_store_in = (ex_op == 2'b10);
        size_in     = ex_funct3[1:0];
        width_ok    = is_load_in ? ((size_in != 2'b11) && !(ex_funct3[2] && ex_funct3[1]))
                                 : (!ex_funct3[2] && (size_in != 2'b11));
        misaligned  = ((size_in == 2'b01) && ex_alu_result[0]) ||
                      ((size_in == 2'b10) && (ex_alu_result[1:0] != 2'b00));
        case (size_in)
            2'b00: begin
                lane_be    = 4'b0001 << ex_alu_result[1:0];
                lane_wdata = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                lane_be    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{ex_store_data[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = ex_store_data;
            end
        endcase
    end

    // Load data: move the addressed lane down, then extend per the latched width.
    always_comb begin
        shifted = mem_rdata >> {regs_q.addr_lo, 3'b000};
        case (regs_q.funct3)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {24'h0, shifted[7:0]};
            3'b101:  load_val = {16'h0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d        = state_q;
        regs_d         = regs_q;
        regs_d.wb_en   = 1'b0;
        regs_d.fault   = 1'b0;
        cnt_inc        = {1'b0, regs_q.cnt} + 9'd1;
        timed_out      = (cnt_inc >= TIMEOUT_W);

        unique case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    regs_d.is_load = is_load_in;
                    regs_d.funct3  = ex_funct3;
                    regs_d.addr_lo = ex_alu_result[1:0];
                    regs_d.rd      = ex_rd;
                    regs_d.reg_wr  = ex_reg_wr;
                    if (!is_load_in && !is_store_in) begin
                        regs_d.wb_en   = ex_reg_wr && (ex_rd != 5'd0);
                        regs_d.wb_addr = ex_rd;
                        regs_d.wb_data = ex_alu_result;
                    end else if (!width_ok) begin
                        regs_d.fault       = 1'b1;
                        regs_d.fault_cause = CAUSE_WIDTH;
                    end else if (misaligned) begin
                        regs_d.fault       = 1'b1;
                        regs_d.fault_cause = CAUSE_MISALIGNED;
                    end else begin
                        state_d          = REQ;
                        regs_d.cnt       = '0;
                        regs_d.mem_req   = 1'b1;
                        regs_d.mem_we    = is_store_in;
                        regs_d.mem_addr  = {ex_alu_result[31:2], 2'b00};
                        regs_d.mem_wdata = lane_wdata;
                        regs_d.mem_be    = lane_be;
                        regs_d.st_cntr   = is_store_in ? size_in + 2'd1 : 2'b00;
                    end
                end
            end
            REQ: begin
                regs_d.cnt = cnt_inc[7:0];
                if (timed_out) begin
                    state_d            = IDLE;
                    regs_d.mem_req     = 1'b0;
                    regs_d.st_cntr     = 2'b00;
                    regs_d.fault       = 1'b1;
                    regs_d.fault_cause = CAUSE_TIMEOUT;
                end else if (mem_gnt) begin
                    state_d        = WAIT;
                    regs_d.mem_req = 1'b0;
                end
            end
            WAIT: begin
                regs_d.cnt = cnt_inc[7:0];
                // A response landing on the deadline cycle still completes the access.
                if (mem_rvalid) begin
                    state_d        = IDLE;
                    regs_d.st_cntr = 2'b00;
                    if (regs_q.is_load) begin
                        regs_d.wb_en   = regs_q.reg_wr && (regs_q.rd != 5'd0);
                        regs_d.wb_addr = regs_q.rd;
                        regs_d.wb_data = load_val;
                    end
                end else if (timed_out) begin
                    state_d            = IDLE;
                    regs_d.st_cntr     = 2'b00;
                    regs_d.fault       = 1'b1;
                    regs_d.fault_cause = CAUSE_TIMEOUT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ex_ready    = (state_q == IDLE);
    assign st_cntr     = regs_q.st_cntr;
    assign mem_req     = regs_q.mem_req;
    assign mem_we      = regs_q.mem_we;
    assign mem_addr    = regs_q.mem_addr;
    assign mem_wdata   = regs_q.mem_wdata;
    assign mem_be      = regs_q.mem_be;
    assign wb_en       = regs_q.wb_en;
    assign wb_addr     = regs_q.wb_addr;
    assign wb_data     = regs_q.wb_data;
    assign fault       = regs_q.fault;
    assign fault_cause = regs_q.fault_cause;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized instructions
// checked against a behavioural model of lane steering, extension, faults and timeout.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [1:0]  ex_op = '0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_alu_result = '0;
    logic [31:0] ex_store_data = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_reg_wr = 1'b0;
    logic [1:0]  st_cntr;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        fault;
    logic [1:0]  fault_cause;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_funct3(ex_funct3),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_wr(ex_reg_wr), .st_cntr(st_cntr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .fault(fault), .fault_cause(fault_cause)
    );

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit expired");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Behavioural reference: value written back by a load.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rdata);
        logic [31:0] v;
        int s;
        v = rdata >> (8 * a);
        case (f3)
            3'b000: begin s = int'(v & 32'hFF);   if (s > 127)   s -= 256;   return 32'(s); end
            3'b001: begin s = int'(v & 32'hFFFF); if (s > 32767) s -= 65536; return 32'(s); end
            3'b100: return v & 32'hFF;
            3'b101: return v & 32'hFFFF;
            default: return v;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'(1 << a);
            2'b01:   return 4'(3 << a);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return (d & 32'hFF) * 32'h0101_0101;
            2'b01:   return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    // Issue one instruction from idle (at a negedge) and follow it to completion.
    // g: REQ cycles before mem_gnt; r: WAIT cycles before mem_rvalid.
    task automatic exec_instr(input string name, input logic [1:0] op, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [4:0] rd, input logic regwr,
                              input int g, input int r, input logic [31:0] rdata);
        bit          is_ld, is_st, legal, mis, timed, in_req, exp_wb, exp_en;
        int          nbytes, e;
        logic [1:0]  exp_st, cause;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_ld;
        is_ld  = (op == 2'b01);
        is_st  = (op == 2'b10);
        nbytes = 1 << f3[1:0];
        legal  = is_ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        mis    = (addr % nbytes) != 0;
        exp_be = ref_be(f3, addr[1:0]);
        exp_wd = ref_wdata(f3, sdata);
        exp_ld = ref_load(f3, addr[1:0], rdata);
        exp_st = is_st ? 2'(f3[1:0] + 2'd1) : 2'b00;

        checks++;
        if (ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_ready: ex_ready=%b required 1", name, ex_ready);
        end
        ex_valid = 1'b1; ex_op = op; ex_funct3 = f3; ex_alu_result = addr;
        ex_store_data = sdata; ex_rd = rd; ex_reg_wr = regwr;
        @(negedge clk);
        ex_valid = 1'b0; ex_alu_result = $urandom; ex_store_data = $urandom; ex_rd = 5'($urandom);

        if (!is_ld && !is_st) begin
            exp_en = regwr && (rd != 5'd0);
            checks++;
            if (wb_en !== exp_en || (exp_en && (wb_addr !== rd || wb_data !== addr)) ||
                fault !== 1'b0 || mem_req !== 1'b0 || st_cntr !== 2'b00 || ex_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s passthrough: wb_en=%b wb_addr=%0d wb_data=%h fault=%b mem_req=%b st_cntr=%b ready=%b required wb_en=%b wb_addr=%0d wb_data=%h",
                         name, wb_en, wb_addr, wb_data, fault, mem_req, st_cntr, ex_ready, exp_en, rd, addr);
            end
        end else if (!legal || mis) begin
            cause = !legal ? 2'b10 : 2'b01;
            checks++;
            if (fault !== 1'b1 || fault_cause !== cause || wb_en !== 1'b0 || mem_req !== 1'b0 ||
                st_cntr !== 2'b00 || ex_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s fault: fault=%b cause=%b wb_en=%b mem_req=%b st_cntr=%b ready=%b required fault=1 cause=%b",
                         name, fault, fault_cause, wb_en, mem_req, st_cntr, ex_ready, cause);
            end
            @(negedge clk);
            checks++;
            if (fault !== 1'b0 || mem_req !== 1'b0 || wb_en !== 1'b0) begin
                errors++;
                $display("FAIL %s fault_pulse: fault=%b mem_req=%b wb_en=%b required 0 0 0", name, fault, mem_req, wb_en);
            end
        end else begin
            timed = (g + 1 + r) > (TO - 1);
            e     = timed ? TO - 1 : g + 1 + r;
            for (int c = 0; c <= e; c++) begin
                in_req = (c <= g);
                checks++;
                if (mem_req !== in_req || ex_ready !== 1'b0 || st_cntr !== exp_st ||
                    wb_en !== 1'b0 || fault !== 1'b0 ||
                    (in_req && (mem_we !== is_st || mem_addr !== {addr[31:2], 2'b00})) ||
                    (in_req && is_st && (mem_be !== exp_be || mem_wdata !== exp_wd))) begin
                    errors++;
                    $display("FAIL %s busy_c%0d: req=%b we=%b addr=%h be=%b wdata=%h st=%b ready=%b wb=%b fault=%b required req=%b we=%b addr=%h be=%b wdata=%h st=%b",
                             name, c, mem_req, mem_we, mem_addr, mem_be, mem_wdata, st_cntr, ex_ready, wb_en, fault,
                             in_req, is_st, {addr[31:2], 2'b00}, exp_be, exp_wd, exp_st);
                end
                mem_gnt    = (c == g);
                mem_rvalid = (c == g + 1 + r) || (c < g && $urandom_range(0, 1) == 1);
                mem_rdata  = (c == g + 1 + r) ? rdata : $urandom;
                @(negedge clk);
            end
            mem_gnt    = 1'b0;
            mem_rvalid = timed;
            mem_rdata  = $urandom;
            exp_wb = !timed && is_ld && regwr && (rd != 5'd0);
            checks++;
            if (ex_ready !== 1'b1 || mem_req !== 1'b0 || st_cntr !== 2'b00 || wb_en !== exp_wb ||
                (exp_wb && (wb_addr !== rd || wb_data !== exp_ld)) || fault !== timed ||
                (timed && fault_cause !== 2'b11)) begin
                errors++;
                $display("FAIL %s done: ready=%b req=%b st=%b wb_en=%b wb_addr=%0d wb_data=%h fault=%b cause=%b required wb_en=%b wb_addr=%0d wb_data=%h fault=%b",
                         name, ex_ready, mem_req, st_cntr, wb_en, wb_addr, wb_data, fault, fault_cause,
                         exp_wb, rd, exp_ld, timed);
            end
            @(negedge clk);
            mem_rvalid = 1'b0;
            checks++;
            if (wb_en !== 1'b0 || fault !== 1'b0 || mem_req !== 1'b0 || ex_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s after: wb_en=%b fault=%b req=%b ready=%b required 0 0 0 1", name, wb_en, fault, mem_req, ex_ready);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if ({ex_ready, mem_req, mem_we, wb_en, fault, st_cntr, mem_be, fault_cause} !== 13'b1_0000_00_0000_00) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b req=%b we=%b wb_en=%b fault=%b st=%b be=%b cause=%b required 1 and zeros",
                     ex_ready, mem_req, mem_we, wb_en, fault, st_cntr, mem_be, fault_cause);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || wb_addr !== 5'h0 || wb_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h wb_addr=%0d wb_data=%h required zeros", mem_addr, mem_wdata, wb_addr, wb_data);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        exec_instr("pt_rd5", 2'b00, 3'b000, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 0, 0, 32'h0);
        exec_instr("pt_rd0", 2'b00, 3'b000, 32'h1234_5678, 32'h0, 5'd0, 1'b1, 0, 0, 32'h0);
        exec_instr("pt_op11", 2'b11, 3'b111, 32'hCAFE_F00D, 32'h0, 5'd9, 1'b1, 0, 0, 32'h0);
        exec_instr("pt_nowr", 2'b00, 3'b010, 32'h0BAD_BEEF, 32'h0, 5'd3, 1'b0, 0, 0, 32'h0);
    endtask

    task automatic test_store();
        exec_instr("sb_103", 2'b10, 3'b000, 32'h0000_0103, 32'h0000_00AB, 5'd7, 1'b1, 1, 1, 32'h0);
        exec_instr("sh_206", 2'b10, 3'b001, 32'h0000_0206, 32'h1357_BEEF, 5'd8, 1'b1, 0, 0, 32'h0);
        exec_instr("sw_300", 2'b10, 3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 5'd2, 1'b1, 0, 2, 32'h0);
    endtask

    task automatic test_load_ext();
        exec_instr("lb_203",  2'b01, 3'b000, 32'h203, 32'h0, 5'd10, 1'b1, 0, 0, 32'h80FF_7F01);
        exec_instr("lbu_203", 2'b01, 3'b100, 32'h203, 32'h0, 5'd11, 1'b1, 0, 0, 32'h80FF_7F01);
        exec_instr("lh_202",  2'b01, 3'b001, 32'h202, 32'h0, 5'd12, 1'b1, 0, 0, 32'h80FF_7F01);
        exec_instr("lhu_200", 2'b01, 3'b101, 32'h200, 32'h0, 5'd13, 1'b1, 1, 0, 32'h80FF_7F01);
        exec_instr("lw_200",  2'b01, 3'b010, 32'h200, 32'h0, 5'd14, 1'b1, 0, 1, 32'h80FF_7F01);
        exec_instr("lb_rd0",  2'b01, 3'b000, 32'h201, 32'h0, 5'd0,  1'b1, 0, 0, 32'h80FF_7F01);
    endtask

    task automatic test_faults();
        exec_instr("lw_mis",  2'b01, 3'b010, 32'h202, 32'h0, 5'd4, 1'b1, 0, 0, 32'h0);
        exec_instr("ld_f011", 2'b01, 3'b011, 32'h200, 32'h0, 5'd4, 1'b1, 0, 0, 32'h0);
        exec_instr("st_f100", 2'b10, 3'b100, 32'h200, 32'h0, 5'd4, 1'b1, 0, 0, 32'h0);
        exec_instr("sh_mis",  2'b10, 3'b001, 32'h201, 32'h0, 5'd4, 1'b1, 0, 0, 32'h0);
    endtask

    task automatic test_timeout();
        exec_instr("to_req",  2'b01, 3'b010, 32'h400, 32'h0, 5'd6, 1'b1, 99, 0, 32'h1111_2222);
        exec_instr("to_wait", 2'b10, 3'b000, 32'h401, 32'h5A, 5'd6, 1'b1, 0, 99, 32'h0);
        exec_instr("edge_ok", 2'b01, 3'b010, 32'h404, 32'h0, 5'd6, 1'b1, 1, 1, 32'h3333_4444);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [6];
        logic [4:0]  r [6];
        for (int i = 0; i < 6; i++) begin
            d[i] = $urandom;
            r[i] = 5'(i + 1);
        end
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) begin
                checks++;
                if (wb_en !== 1'b1 || wb_addr !== r[i-1] || wb_data !== d[i-1] || ex_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_%0d: wb_en=%b wb_addr=%0d wb_data=%h ready=%b required 1 %0d %h 1",
                             i - 1, wb_en, wb_addr, wb_data, ex_ready, r[i-1], d[i-1]);
                end
            end
            if (i < 6) begin
                ex_valid = 1'b1; ex_op = 2'b00; ex_alu_result = d[i]; ex_rd = r[i]; ex_reg_wr = 1'b1;
            end else begin
                ex_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    // Start a store, abort it with an asynchronous reset mid-cycle in REQ (phase 0) or WAIT (phase 1).
    task automatic reset_during_store(input int phase);
        ex_valid = 1'b1; ex_op = 2'b10; ex_funct3 = 3'b010; ex_alu_result = 32'h40;
        ex_store_data = 32'hA5A5_A5A5; ex_rd = 5'd1; ex_reg_wr = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || st_cntr !== 2'b11) begin
            errors++;
            $display("FAIL rst%0d_pre: req=%b st=%b required 1 11", phase, mem_req, st_cntr);
        end
        if (phase == 1) begin
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || st_cntr !== 2'b00 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst%0d_async: req=%b st=%b ready=%b required 0 00 1", phase, mem_req, st_cntr, ex_ready);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            checks++;
            if (wb_en !== 1'b0 || fault !== 1'b0 || mem_req !== 1'b0 || st_cntr !== 2'b00) begin
                errors++;
                $display("FAIL rst%0d_quiet%0d: wb_en=%b fault=%b req=%b st=%b required zeros", phase, k, wb_en, fault, mem_req, st_cntr);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset_during_store(0);
        reset_during_store(1);
        exec_instr("lw_after_rst", 2'b01, 3'b010, 32'h0000_0500, 32'h0, 5'd20, 1'b1, 0, 0, 32'h0123_4567);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 80; i++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            exec_instr($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                       a, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 4), $urandom_range(0, 2), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_store();
        test_load_ext();
        test_faults();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the 4-stage pipeline, between execute and register writeback. It accepts one instruction per handshake from execute and performs the data-memory access with byte-lane steering and load extension. It then drives the writeback port and the in-flight store size (`st_cntr`) that the data-hazard unit consumes for forwarding and store-to-load checks. Non-memory instructions pass through with one cycle of latency.

## Interface
- `TIMEOUT`, 255: max cycles in REQ+WAIT before the access is abandoned (1..255).
- `clk`  in  1  clock.
- `rstn`  in  1  asynchronous active-low reset.
- `ex_valid`  in  1  execute presents an instruction.
- `ex_ready`  out  1  LSU can accept; high only in IDLE.
- `ex_op`  in  2  00 ALU passthrough, 01 load, 10 store, 11 treated as 00.
- `ex_funct3`  in  3  RV32I width/sign field.
- `ex_alu_result`  in  32  effective address (load/store) or result (passthrough).
- `ex_store_data`  in  32  rs2 value for stores.
- `ex_rd`  in  5  destination register.
- `ex_reg_wr`  in  1  instruction writes rd.
- `st_cntr`  out  2  in-flight store size: 00 none, 01 byte, 10 half, 11 word.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word-aligned address (bits [1:0] = 0).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_be`  out  4  byte enables.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  response valid (loads and stores).
- `mem_rdata`  in  32  load data.
- `wb_en`  out  1  one-cycle register write strobe.
- `wb_addr`  out  5  register address.
- `wb_data`  out  32  write data.
- `fault`  out  1  one-cycle fault pulse.
- `fault_cause`  out  2  01 misaligned, 10 illegal width, 11 timeout; valid with `fault`.

## Operation
- States: IDLE, REQ, WAIT.
- Accept: `ex_valid & ex_ready`. All fields are latched on accept.
- Passthrough accept:
  - Stay in IDLE.
  - Next cycle: `wb_en = ex_reg_wr & (rd != 0)`, `wb_data = alu_result`.
- Legal widths:
  - Load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store: 000 SB, 001 SH, 010 SW.
  - Any other value → `fault` with cause 10, next cycle. No bus access, no writeback. Stay in IDLE.
- Misaligned access: half-word with addr[0]=1, or word with addr[1:0]≠0. Result: `fault` with cause 01, next cycle. No bus access, no writeback.
- Legal memory access:
  - Go to REQ. Drive `mem_req`, `mem_we`, `mem_addr = {addr[31:2],2'b00}`, `mem_wdata`, `mem_be`.
  - Hold all of them stable until `mem_gnt`, then go to WAIT.
- Store lanes:
  - SB: `be = 0001 << addr[1:0]`, wdata = byte replicated ×4.
  - SH: `be = addr[1] ? 1100 : 0011`, wdata = half replicated ×2.
  - SW: `be = 1111`.
- WAIT:
  - On `mem_rvalid`, go to IDLE.
  - For a load: `rdata >> (8*addr[1:0])`, then sign-extend (LB/LH) or zero-extend (LBU/LHU). `wb_en` pulses the next cycle if rd ≠ 0.
  - A store produces no writeback.
- `st_cntr`:
  - Set from the store width at accept (SB 01, SH 10, SW 11).
  - Held through REQ/WAIT. Returns to 00 in the cycle after the store's `mem_rvalid`, or after a timeout.
  - 00 for every other instruction.
- Timeout:
  - Counter cleared on entry to REQ, incremented each cycle in REQ/WAIT.
  - On reaching `TIMEOUT`: drop `mem_req` and return to IDLE. Next cycle: `fault` with cause 11, no writeback.
- `mem_rvalid` in IDLE or REQ is ignored, including a late response after a timeout or reset.
- `ex_valid` while busy is ignored. Execute must hold the instruction until `ex_ready`.

## Timing
- Reset values:
  - State IDLE, `ex_ready` = 1.
  - `mem_req`, `mem_we`, `wb_en`, `fault` = 0.
  - `st_cntr`, `mem_be`, `fault_cause` = 0.
  - `mem_addr`, `mem_wdata`, `wb_addr`, `wb_data` = 0.
  - Timeout counter = 0.
- All outputs are registered, except `ex_ready`, which is decoded from state.
- Passthrough: accept in cycle T → `wb_en` in T+1. Back-to-back passthroughs sustain one per cycle.
- Load, best case: accept T; `mem_req` T+1 with `mem_gnt`; WAIT T+2 with `mem_rvalid`; `wb_en` T+3.
  - `ex_ready` is low in T+1..T+2 and high again in T+3.
- Store, best case: same as load. `st_cntr` ≠ 0 in T+1..T+2 and 00 in T+3.
- Fault: `fault` in T+1. `ex_ready` stays high.
- Asynchronous reset mid-access:
  - `mem_req` and `st_cntr` drop immediately.
  - No writeback and no fault for the aborted access.

## Test plan
- Passthrough, `alu_result`=0x1234_5678, rd=5 → `wb_en` next cycle, `wb_addr`=5, `wb_data`=0x1234_5678. Same instruction with rd=0 → `wb_en` stays 0.
- SB addr 0x103, data 0xAB → `mem_addr`=0x100, `be`=1000, wdata=0xABABABAB, `st_cntr`=01 until the cycle after `mem_rvalid`, no writeback.
- `mem_rdata`=0x80FF_7F01:
  - LB addr 0x203 → `wb_data`=0xFFFF_FF80.
  - LBU addr 0x203 → 0x0000_0080.
  - LH addr 0x202 → 0xFFFF_80FF.
  - LW addr 0x200 → 0x80FF_7F01.
- LW addr 0x202 → `fault` with cause 01 next cycle, `mem_req` never asserted. Load funct3=011 → cause 10.
- `TIMEOUT`=4, `mem_gnt` held low → `mem_req` drops after 4 cycles, cause 11, no writeback. A late `mem_rvalid` is ignored.
- Reset asserted during WAIT of a store → `st_cntr`=00 and `mem_req`=0 immediately. After release, a new LW completes normally.
